// File: rtl/booth_pkg.sv
// Shared types, widths and helpers for the radix-4 Booth multiplier sequencer.
package booth_pkg;

   localparam int OP_W      = 16;
   localparam int RES_W     = 32;
   localparam int ACC_W     = 40;
   localparam int MUL_STEPS = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_RECOVER = 3'd5
   } state_t;

   function automatic logic [ACC_W-1:0] sext_res(input logic [RES_W-1:0] v);
      return {{(ACC_W-RES_W){v[RES_W-1]}}, v};
   endfunction

endpackage

// File: rtl/booth_seq_if.sv
// Operand and result valid/ready ports of the Booth sequencer.
interface booth_seq_if;
   import booth_pkg::*;

   logic            op_valid;
   logic            op_ready;
   logic [OP_W-1:0] op_a;
   logic [OP_W-1:0] op_b;
   logic            res_valid;
   logic            res_ready;
   logic [RES_W-1:0] res_data;

   modport master (
      output op_valid, op_a, op_b, res_ready,
      input  op_ready, res_valid, res_data
   );

   modport slave (
      input  op_valid, op_a, op_b, res_ready,
      output op_ready, res_valid, res_data
   );

endinterface

// File: rtl/booth_seq_fifo.sv
// DEPTH-entry synchronous FIFO holding packed {a, b} operand pairs; head is read
// combinationally so the sequencer can latch it on the pop edge.
module booth_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // A pop frees the head slot, so a push into a full FIFO is accepted alongside it.
   always_comb begin
      do_pop_s  = pop && (count_r != '0);
      do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == '0);

endmodule

// File: rtl/booth_seq.sv
// Sequencer feeding one Booth multiplication at a time from an operand FIFO.
// Optional running accumulator enabled by defining BOOTH_SEQ_ACC_EN.
module booth_seq
   import booth_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   booth_seq_if.slave       bus,
   output logic             err,
   output logic             mul_start,
   output logic             mul_ack,
   output logic             mul_irq_enable,
   output logic [OP_W-1:0]  mul_data_a,
   output logic [OP_W-1:0]  mul_data_b,
   input  logic             mul_busy,
   input  logic             mul_irq,
   input  logic [RES_W-1:0] mul_result
`ifdef BOOTH_SEQ_ACC_EN
   ,
   input  logic             acc_clr,
   output logic [ACC_W-1:0] acc_data
`endif
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   state_t             state_r;
   state_t             state_next_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [2*OP_W-1:0]  head_s;
   logic               push_s;
   logic               pop_s;
   logic               load_s;
   logic               timeout_s;
   logic               can_capture_s;
   logic [WD_W-1:0]    wd_r;
   logic               err_r;
   logic               start_r;
   logic               ack_r;
   logic               res_valid_r;
   logic [RES_W-1:0]   res_data_r;
   logic [OP_W-1:0]    data_a_r;
   logic [OP_W-1:0]    data_b_r;

   assign push_s = bus.op_valid && !fifo_full_s;

   booth_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*OP_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data ({bus.op_a, bus.op_b}),
      .pop       (pop_s),
      .head_data (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Next-state logic; the watchdog only runs while no completion is pending.
   always_comb begin
      state_next_s  = state_r;
      pop_s         = 1'b0;
      timeout_s     = 1'b0;
      can_capture_s = !res_valid_r || bus.res_ready;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s && !mul_busy) begin
               pop_s        = 1'b1;
               state_next_s = ST_LAUNCH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            state_next_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_irq) begin
               if (can_capture_s) begin
                  state_next_s = ST_CAPTURE;
               end else begin
                  state_next_s = ST_WAIT;
               end
            end else if (wd_r == WD_LIMIT) begin
               timeout_s    = 1'b1;
               state_next_s = ST_RECOVER;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_CAPTURE: begin
            state_next_s = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!mul_busy && !mul_irq) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_RECOVER: begin
            // First RECOVER cycle carries the ack pulse; only then wait for idle.
            if (ack_r) begin
               state_next_s = ST_RECOVER;
            end else if (!mul_busy) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RECOVER;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      load_s = (state_r == ST_WAIT) && (state_next_s == ST_CAPTURE);
   end

   // State, handshake outputs, operand latch, watchdog and result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         start_r     <= 1'b0;
         ack_r       <= 1'b0;
         data_a_r    <= '0;
         data_b_r    <= '0;
         wd_r        <= '0;
         err_r       <= 1'b0;
         res_valid_r <= 1'b0;
         res_data_r  <= '0;
      end else begin
         state_r <= state_next_s;
         start_r <= (state_next_s == ST_LAUNCH);
         ack_r   <= (state_next_s == ST_CAPTURE) ||
                    ((state_next_s == ST_RECOVER) && (state_r != ST_RECOVER));
         if (pop_s) begin
            data_a_r <= head_s[2*OP_W-1:OP_W];
            data_b_r <= head_s[OP_W-1:0];
            wd_r     <= '0;
         end else if ((state_r == ST_LAUNCH) || ((state_r == ST_WAIT) && !mul_irq)) begin
            wd_r <= wd_r + 1'b1;
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end
         if (load_s) begin
            res_data_r  <= mul_result;
            res_valid_r <= 1'b1;
         end else if (res_valid_r && bus.res_ready) begin
            res_valid_r <= 1'b0;
         end
      end
   end

`ifdef BOOTH_SEQ_ACC_EN
   logic [ACC_W-1:0] acc_r;

   // Running sum of products; a clear coinciding with a capture keeps that product.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r <= '0;
      end else if (acc_clr) begin
         acc_r <= load_s ? sext_res(mul_result) : '0;
      end else if (load_s) begin
         acc_r <= acc_r + sext_res(mul_result);
      end
   end

   assign acc_data = acc_r;
`endif

   assign bus.op_ready    = !fifo_full_s;
   assign bus.res_valid   = res_valid_r;
   assign bus.res_data    = res_data_r;
   assign err             = err_r;
   assign mul_start       = start_r;
   assign mul_ack         = ack_r;
   assign mul_irq_enable  = 1'b1;
   assign mul_data_a      = data_a_r;
   assign mul_data_b      = data_b_r;

endmodule

// File: tb/tb_booth_seq.sv
// Directed bench for booth_seq with a behavioural Booth multiplier beside it.
module tb_booth_seq;
   import booth_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             err;
   logic             mul_start;
   logic             mul_ack;
   logic             mul_irq_enable;
   logic [OP_W-1:0]  mul_data_a;
   logic [OP_W-1:0]  mul_data_b;
   logic             mul_busy;
   logic             mul_irq;
   logic [RES_W-1:0] mul_result;
`ifdef BOOTH_SEQ_ACC_EN
   logic             acc_clr;
   logic [ACC_W-1:0] acc_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit hang    = 1'b0;
   logic [RES_W-1:0] res_q[$];

   booth_seq_if bus_if();

   booth_seq #(.DEPTH(4), .TIMEOUT(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus_if),
      .err            (err),
      .mul_start      (mul_start),
      .mul_ack        (mul_ack),
      .mul_irq_enable (mul_irq_enable),
      .mul_data_a     (mul_data_a),
      .mul_data_b     (mul_data_b),
      .mul_busy       (mul_busy),
      .mul_irq        (mul_irq),
      .mul_result     (mul_result)
`ifdef BOOTH_SEQ_ACC_EN
      ,
      .acc_clr        (acc_clr),
      .acc_data       (acc_data)
`endif
   );

   always #5 clk = ~clk;

   // Multiplier model: registered start edge detect, MUL_STEPS busy cycles, irq held until ack.
   logic start_q, start_qq;
   int   steps;
   always @(posedge clk) begin
      if (reset) begin
         mul_busy <= 1'b0; mul_irq <= 1'b0; mul_result <= '0;
         start_q <= 1'b0; start_qq <= 1'b0; steps <= 0;
      end else begin
         start_q  <= mul_start;
         start_qq <= start_q;
         if (mul_ack) begin
            mul_irq <= 1'b0; mul_busy <= 1'b0;
         end else if (start_q && !start_qq && !mul_busy) begin
            mul_busy <= 1'b1; steps <= MUL_STEPS;
         end else if (mul_busy && !hang) begin
            if (steps == 1) begin
               mul_busy   <= 1'b0;
               mul_irq    <= 1'b1;
               mul_result <= {{16{mul_data_a[15]}}, mul_data_a} * {{16{mul_data_b[15]}}, mul_data_b};
            end else begin
               steps <= steps - 1;
            end
         end
      end
   end

   // Result monitor: records every accepted product.
   always @(posedge clk) begin
      if (!reset && bus_if.res_valid && bus_if.res_ready) res_q.push_back(bus_if.res_data);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_op(input logic [15:0] a, input logic [15:0] b);
      bus_if.op_valid = 1'b1; bus_if.op_a = a; bus_if.op_b = b;
      for (int i = 0; i < 200 && !bus_if.op_ready; i++) tick();
      chk("push_ready", 40'(bus_if.op_ready), 40'd1);
      tick();
      bus_if.op_valid = 1'b0;
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, output logic [31:0] data,
                        output int lat, output int starts, output int acks);
      bit ok = 1'b0;
      data = 'x;
      push_op(a, b);
      lat = 1; starts = 0; acks = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick(); lat++;
         starts += int'(mul_start); acks += int'(mul_ack);
         if (bus_if.res_valid) begin ok = 1'b1; data = bus_if.res_data; end
      end
      chk("op_done", 40'(ok), 40'd1);
      for (int i = 0; i < 4; i++) begin
         tick(); starts += int'(mul_start); acks += int'(mul_ack);
      end
   endtask

   initial begin
      logic [31:0] d;
      int lat, st, ak, n;
      bus_if.op_valid = 1'b0; bus_if.op_a = '0; bus_if.op_b = '0; bus_if.res_ready = 1'b1;
`ifdef BOOTH_SEQ_ACC_EN
      acc_clr = 1'b0;
`endif
      reset = 1'b1;
      tick(); tick();
      chk("rst_op_ready", 40'(bus_if.op_ready), 40'd1);
      chk("rst_res_valid", 40'(bus_if.res_valid), 40'd0);
      chk("rst_res_data", 40'(bus_if.res_data), 40'd0);
      chk("rst_err", 40'(err), 40'd0);
      chk("rst_start", 40'(mul_start), 40'd0);
      chk("rst_ack", 40'(mul_ack), 40'd0);
      chk("rst_data_a", 40'(mul_data_a), 40'd0);
      chk("rst_data_b", 40'(mul_data_b), 40'd0);
      chk("irq_enable", 40'(mul_irq_enable), 40'd1);
      reset = 1'b0;
      tick();

      // Single op 3 * -5; latency counted from the push cycle.
      do_op(16'd3, 16'hFFFB, d, lat, st, ak);
      chk("single_data", 40'(d), 40'hFFFF_FFF1);
      chk("single_lat", 40'(lat), 40'd13);
      chk("single_start", 40'(st), 40'd1);
      chk("single_ack", 40'(ak), 40'd1);
      chk("single_cleared", 40'(bus_if.res_valid), 40'd0);

      do_op(16'h8000, 16'h8000, d, lat, st, ak);
      chk("corner_minmin", 40'(d), 40'h4000_0000);
      do_op(16'h7FFF, 16'h8000, d, lat, st, ak);
      chk("corner_maxmin", 40'(d), 40'hC000_8000);
      do_op(16'd0, 16'h1234, d, lat, st, ak);
      chk("corner_zero", 40'(d), 40'd0);

      // Burst of DEPTH+1 pairs.
      res_q.delete();
      push_op(16'd1, 16'd1);
      push_op(16'd2, 16'hFFFD);
      push_op(16'hFFFC, 16'd5);
      push_op(16'd100, 16'hFF9C);
      push_op(16'hFFF9, 16'hFFF7);
      chk("burst_full", 40'(bus_if.op_ready), 40'd0);
      for (int i = 0; i < 300 && res_q.size() < 5; i++) tick();
      repeat (20) tick();
      chk("burst_count", 40'(res_q.size()), 40'd5);
      if (res_q.size() == 5) begin
         chk("burst_0", 40'(res_q[0]), 40'd1);
         chk("burst_1", 40'(res_q[1]), 40'hFFFF_FFFA);
         chk("burst_2", 40'(res_q[2]), 40'hFFFF_FFEC);
         chk("burst_3", 40'(res_q[3]), 40'hFFFF_D8F0);
         chk("burst_4", 40'(res_q[4]), 40'h3F);
      end

      // Backpressure: second completion stalls with irq pending.
      res_q.delete();
      bus_if.res_ready = 1'b0;
      push_op(16'd6, 16'd7);
      push_op(16'hFFF8, 16'd9);
      ak = 0;
      for (int i = 0; i < 60; i++) begin tick(); ak += int'(mul_ack); end
      chk("bp_acks", 40'(ak), 40'd1);
      chk("bp_valid", 40'(bus_if.res_valid), 40'd1);
      chk("bp_hold", 40'(bus_if.res_data), 40'h2A);
      chk("bp_irq_pending", 40'(mul_irq), 40'd1);
      bus_if.res_ready = 1'b1;
      for (int i = 0; i < 50 && res_q.size() < 2; i++) begin tick(); ak += int'(mul_ack); end
      repeat (5) begin tick(); ak += int'(mul_ack); end
      chk("bp_count", 40'(res_q.size()), 40'd2);
      if (res_q.size() == 2) begin
         chk("bp_first", 40'(res_q[0]), 40'h2A);
         chk("bp_second", 40'(res_q[1]), 40'hFFFF_FFB8);
      end
      chk("bp_acks_total", 40'(ak), 40'd2);

      // Timeout: multiplier never raises irq.
      res_q.delete();
      hang = 1'b1;
      push_op(16'd1, 16'd2);
      for (int i = 0; i < 20 && !mul_start; i++) tick();
      chk("to_launch", 40'(mul_start), 40'd1);
      n = 0; ak = 0;
      for (int i = 0; i < 200 && !err; i++) begin tick(); n++; ak += int'(mul_ack); end
      chk("to_cycles", 40'(n), 40'd64);
      repeat (6) begin tick(); ak += int'(mul_ack); end
      chk("to_ack", 40'(ak), 40'd1);
      chk("to_nores", 40'(res_q.size()), 40'd0);
      hang = 1'b0;
      do_op(16'd2, 16'd2, d, lat, st, ak);
      chk("to_next", 40'(d), 40'd4);
      chk("to_sticky", 40'(err), 40'd1);

      // Reset in WAIT with another pair queued.
      push_op(16'd5, 16'd5);
      push_op(16'd7, 16'd7);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_res_valid", 40'(bus_if.res_valid), 40'd0);
      chk("mr_res_data", 40'(bus_if.res_data), 40'd0);
      chk("mr_err", 40'(err), 40'd0);
      chk("mr_start", 40'(mul_start), 40'd0);
      chk("mr_data_a", 40'(mul_data_a), 40'd0);
      chk("mr_op_ready", 40'(bus_if.op_ready), 40'd1);
      st = 0;
      repeat (10) begin tick(); st += int'(mul_start); end
      chk("mr_fifo_empty", 40'(st), 40'd0);
      do_op(16'd3, 16'd3, d, lat, st, ak);
      chk("mr_after", 40'(d), 40'd9);

`ifdef BOOTH_SEQ_ACC_EN
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      do_op(16'd2, 16'd3, d, lat, st, ak);
      do_op(16'd4, 16'd5, d, lat, st, ak);
      chk("acc_sum", acc_data, 40'd26);
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      chk("acc_clr", acc_data, 40'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed stuck simulation, required completion");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/booth_seq.md
Name: booth_seq

Overview:
- Upstream sequencer for the radix-4 Booth multiplier (`booth`).
- Buffers operand pairs from a valid/ready producer in a small FIFO and launches one multiplication at a time.
- Drives the multiplier's start/ack/irq_enable protocol, captures each signed 32-bit product and presents it on a valid/ready result port.
- Sits between the bus-side operand source and the multiplier; the multiplier is instantiated beside it, not inside it.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, 2..16.
- TIMEOUT, 64, cycles allowed from launch to mul_irq before err is raised; minimum 16.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  reset; synchronous, active-high.
- op_valid  in  1  operand pair offered.
- op_ready  out  1  FIFO can accept a pair (not full).
- op_a  in  16  signed multiplicand.
- op_b  in  16  signed multiplier.
- res_valid  out  1  product held in result register.
- res_ready  in  1  consumer accepts product.
- res_data  out  32  signed product.
- err  out  1  sticky timeout flag; cleared only by reset.
- mul_start  out  1  to multiplier start; rising-edge sensitive.
- mul_ack  out  1  to multiplier ack.
- mul_irq_enable  out  1  tied 1; multiplier always holds irq until acked.
- mul_data_a  out  16  operand A, stable for whole operation.
- mul_data_b  out  16  operand B, stable for whole operation.
- mul_busy  in  1  multiplier busy.
- mul_irq  in  1  multiplier done.
- mul_result  in  32  multiplier product, valid while mul_irq=1.

Behaviour:
- Reset values:
  - FIFO empty; op_ready=1.
  - res_valid=0, res_data=0, err=0.
  - mul_start=0, mul_ack=0.
  - mul_data_a/b=0.
  - FSM in IDLE.
- Reset mid-operation aborts the operation. The multiplier shares reset, so both return to idle together.
- FIFO:
  - Push when op_valid&&op_ready.
  - Pop on the IDLE->LAUNCH transition.
  - Push and pop in the same cycle are legal, including when full: op_ready=!full is registered-free and does not consider the pop.
  - Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
- FSM states (one-hot or binary, implementer's choice):
  - IDLE: mul_start=0. If FIFO non-empty and mul_busy=0, pop the head into the mul_data_a/b registers and go to LAUNCH.
  - LAUNCH: mul_start=1 for exactly one cycle; the watchdog counter clears; go to WAIT.
  - WAIT: mul_start=0; operands held. Go to CAPTURE when mul_irq=1. The watchdog increments each cycle; when it reaches TIMEOUT, set err=1 and go to RECOVER.
  - CAPTURE: entered only if res_valid=0 or res_ready=1 this cycle; otherwise stall in WAIT with irq pending (the multiplier holds irq). On entry, res_data<=mul_result, res_valid<=1, mul_ack=1 for one cycle; go to DRAIN.
  - DRAIN: mul_ack=0; wait until mul_busy=0 && mul_irq=0; go to IDLE.
  - RECOVER: pulse mul_ack for one cycle, then wait mul_busy=0; go to IDLE. The operand pair is dropped and no result is produced.
- mul_start is low for at least one cycle between launches, guaranteed by the WAIT/DRAIN/IDLE path, so the multiplier's edge detector always sees a rising edge.
- Result port:
  - res_valid clears on res_valid&&res_ready unless CAPTURE reloads in the same cycle (reload wins).
  - res_data is stable while res_valid=1 && res_ready=0.
- Latency from op accept (empty FIFO, idle) to res_valid: 1 (push) + 1 IDLE + 1 LAUNCH + 1 multiplier edge + 8 busy + 1 CAPTURE = 13 cycles.
- Arithmetic is two's complement. The product fits 32 bits for all inputs except (-32768)*(-32768) = +2^30, which also fits. No saturation.

Optional Feature:
- Macro BOOTH_SEQ_ACC_EN.
- Defined:
  - Adds input acc_clr (1) and output acc_data (40, signed).
  - In CAPTURE, acc_data <= acc_data + sign-extended mul_result.
  - acc_clr=1 zeroes the accumulator the next cycle; if it coincides with CAPTURE, the result is 0 + mul_result.
  - Reset value 0; wraps modulo 2^40.
- Undefined: ports absent; no accumulator logic.

Decomposition:
- Package booth_pkg:
  - FSM state typedef (IDLE, LAUNCH, WAIT, CAPTURE, DRAIN, RECOVER).
  - Widths OP_W=16, RES_W=32, ACC_W=40.
  - Multiplier busy length constant MUL_STEPS=8.
- One sub-module: booth_seq_fifo (DEPTH x 32-bit synchronous FIFO, push/pop/full/empty).

Test Plan:
- Single op: push a=3, b=-5 with res_ready=1 → res_valid after 13 cycles, res_data=-15; mul_ack pulsed once; mul_start high exactly one cycle.
- Corner operands: (-32768,-32768) → 1073741824; (32767,-32768) → -1073709056; (0,x) → 0.
- Burst: push DEPTH+1 pairs back-to-back → op_ready low when full; all products emerge in order; no lost or duplicate results.
- Backpressure: res_ready=0 during second completion → res_data holds first product; mul_ack not asserted until the slot frees; the second product follows intact.
- Timeout: model multiplier never asserting mul_irq → err=1 at TIMEOUT cycles after launch; FSM returns to IDLE; next op (a=2, b=2) yields 4.
- Reset mid-WAIT: assert reset for one cycle → all outputs at reset values next cycle; FIFO empty. With BOOTH_SEQ_ACC_EN: ops 2*3, 4*5 → acc_data=26; acc_clr → 0.
